// File: rtl/sha256_block_sequencer.sv
// Drives a SHA-256 compression core: pads a big-endian word stream into 512-bit
// blocks, issues start/done handshakes, chains H between blocks and emits the digest.
module sha256_block_sequencer #(
  parameter int unsigned CORE_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  input  logic [1:0]       in_bytes,
  output logic             core_start,
  output logic [15:0][31:0] core_message,
  output logic [7:0][31:0] core_in,
  input  logic             core_done,
  input  logic [7:0][31:0] core_sha256,
  output logic [7:0][31:0] digest,
  output logic             digest_valid,
  output logic             error,
  output logic             busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FILL  = 3'd1;
  localparam logic [2:0] PAD   = 3'd2;
  localparam logic [2:0] LEN   = 3'd3;
  localparam logic [2:0] START = 3'd4;
  localparam logic [2:0] WAIT  = 3'd5;

  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  logic [2:0]       state_reg;
  logic [4:0]       idx_reg;
  logic [63:0]      bitlen_reg;
  logic [7:0][31:0] h_reg;
  logic [7:0][31:0] digest_reg;
  logic             digest_valid_reg;
  logic             marker_pending_reg;
  logic             pad_begun_reg;
  logic             final_reg;
  logic [31:0]      wait_cnt_reg;
  logic [31:0]      msg_buf [16];

  logic        accept;
  logic        pad_write;
  logic        timeout_hit;
  logic [31:0] word_in;
  logic [5:0]  add_bits;

  // A short last word keeps its leading bytes and carries the 0x80 marker itself.
  always_comb begin
    word_in  = in_data;
    add_bits = 6'd32;
    if (in_last) begin
      case (in_bytes)
        2'd1: begin word_in = {in_data[31:24], 8'h80, 16'h0000}; add_bits = 6'd8;  end
        2'd2: begin word_in = {in_data[31:16], 8'h80, 8'h00};    add_bits = 6'd16; end
        2'd3: begin word_in = {in_data[31:8], 8'h80};            add_bits = 6'd24; end
        default: ;
      endcase
    end
  end

  assign in_ready    = !reset && ((state_reg == IDLE) || (state_reg == FILL));
  assign accept      = in_valid && in_ready;
  assign pad_write   = (state_reg == PAD) && (idx_reg != 5'd16) &&
                       !((idx_reg == 5'd14) && !marker_pending_reg);
  assign timeout_hit = (CORE_TIMEOUT != 0) && (wait_cnt_reg == CORE_TIMEOUT - 1);
  assign core_start  = !reset && (state_reg == START);
  assign error       = !reset && (state_reg == WAIT) && !core_done && timeout_hit;
  assign busy        = !reset && (state_reg != IDLE);
  assign core_in     = h_reg;
  assign digest      = digest_reg;
  assign digest_valid = digest_valid_reg;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_msg
      assign core_message[gi] = msg_buf[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (accept) begin
        msg_buf[idx_reg[3:0]] <= word_in;
      end else if (pad_write) begin
        msg_buf[idx_reg[3:0]] <= marker_pending_reg ? 32'h8000_0000 : 32'h0000_0000;
      end else if (state_reg == LEN) begin
        msg_buf[14] <= bitlen_reg[63:32];
        msg_buf[15] <= bitlen_reg[31:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= IDLE;
      idx_reg            <= 5'd0;
      bitlen_reg         <= 64'd0;
      h_reg              <= IV;
      digest_reg         <= '0;
      digest_valid_reg   <= 1'b0;
      marker_pending_reg <= 1'b0;
      pad_begun_reg      <= 1'b0;
      final_reg          <= 1'b0;
      wait_cnt_reg       <= 32'd0;
    end else begin
      digest_valid_reg <= 1'b0;
      case (state_reg)
        IDLE, FILL: begin
          if (accept) begin
            idx_reg    <= idx_reg + 5'd1;
            bitlen_reg <= bitlen_reg + {58'd0, add_bits};
            if (in_last) begin
              marker_pending_reg <= (in_bytes == 2'd0);
              pad_begun_reg      <= 1'b1;
              state_reg          <= PAD;
            end else if (idx_reg == 5'd15) begin
              final_reg <= 1'b0;
              state_reg <= START;
            end else begin
              state_reg <= FILL;
            end
          end
        end
        PAD: begin
          if (idx_reg == 5'd16) begin
            final_reg <= 1'b0;
            state_reg <= START;
          end else if ((idx_reg == 5'd14) && !marker_pending_reg) begin
            state_reg <= LEN;
          end else begin
            marker_pending_reg <= 1'b0;
            idx_reg            <= idx_reg + 5'd1;
          end
        end
        LEN: begin
          final_reg <= 1'b1;
          state_reg <= START;
        end
        START: begin
          idx_reg      <= 5'd0;
          wait_cnt_reg <= 32'd0;
          state_reg    <= WAIT;
        end
        WAIT: begin
          if (core_done) begin
            h_reg <= core_sha256;
            if (final_reg) begin
              digest_reg       <= core_sha256;
              digest_valid_reg <= 1'b1;
              h_reg            <= IV;
              bitlen_reg       <= 64'd0;
              pad_begun_reg    <= 1'b0;
              state_reg        <= IDLE;
            end else begin
              state_reg <= pad_begun_reg ? PAD : FILL;
            end
          end else if (timeout_hit) begin
            h_reg              <= IV;
            bitlen_reg         <= 64'd0;
            idx_reg            <= 5'd0;
            marker_pending_reg <= 1'b0;
            pad_begun_reg      <= 1'b0;
            state_reg          <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 32'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Bench for sha256_block_sequencer: behavioural SHA-256 core stub plus block and
// digest scoreboards fed from a reference padding model.
module tb_sha256_block_sequencer;

  localparam int unsigned TMO = 20;

  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };
  localparam logic [7:0][31:0] ABC_D = {
    32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
    32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf
  };
  localparam logic [7:0][31:0] LONG_D = {
    32'h19db06c1, 32'hf6ecedd4, 32'h64ff2167, 32'ha33ce459,
    32'h0c3e6039, 32'he5c02693, 32'hd20638b8, 32'h248d6a61
  };
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef logic [15:0][31:0] blk_t;
  typedef struct {
    blk_t blk;
    bit   last;
  } exp_blk_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_data = 32'd0;
  logic              in_last = 1'b0;
  logic [1:0]        in_bytes = 2'd0;
  logic              core_start;
  logic [15:0][31:0] core_message;
  logic [7:0][31:0]  core_in;
  logic              core_done = 1'b0;
  logic [7:0][31:0]  core_sha256 = '0;
  logic [7:0][31:0]  digest;
  logic              digest_valid;
  logic              error;
  logic              busy;

  sha256_block_sequencer #(.CORE_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_bytes(in_bytes),
    .core_start(core_start), .core_message(core_message), .core_in(core_in),
    .core_done(core_done), .core_sha256(core_sha256),
    .digest(digest), .digest_valid(digest_valid), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts = 0;
  int digests_seen = 0;
  int errors_seen = 0;
  int start_cyc = 0;
  int err_cyc = 0;
  int stub_lat = 3;
  int pend_left = 0;
  bit stub_on = 1'b1;
  bit pend = 1'b0;
  bit pend_last = 1'b0;
  bit stale = 1'b0;
  bit expect_error = 1'b0;
  logic [7:0][31:0] pend_res = '0;
  logic [7:0][31:0] tb_h = '0;
  exp_blk_t         exp_blk_q[$];
  logic [7:0][31:0] exp_dig_q[$];
  byte unsigned     msg_q[$];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference compression including the feed-forward add, as the real core does.
  function automatic logic [7:0][31:0] compress(input logic [7:0][31:0] hin, input blk_t m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    logic [7:0][31:0] r;
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = hin[0]; b = hin[1]; c = hin[2]; d = hin[3];
    e = hin[4]; f = hin[5]; g = hin[6]; hh = hin[7];
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    r[0] = hin[0] + a; r[1] = hin[1] + b; r[2] = hin[2] + c; r[3] = hin[3] + d;
    r[4] = hin[4] + e; r[5] = hin[5] + f; r[6] = hin[6] + g; r[7] = hin[7] + hh;
    return r;
  endfunction

  task automatic chk_b(input string name, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", name, obs, exp);
    end
  endtask

  task automatic chk_i(input string name, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  task automatic chk_v(input string name, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock: sample just after the edge, act as the core, score outputs.
  task automatic tick();
    exp_blk_t cur;
    @(posedge clk);
    #1;
    cyc++;
    core_done = 1'b0;
    if (core_start) begin
      starts++;
      start_cyc = cyc;
      cur.last = 1'b0;
      chk_i("start_expected", int'(exp_blk_q.size() > 0), 1);
      if (exp_blk_q.size() > 0) begin
        cur = exp_blk_q.pop_front();
        chk_v("core_message", core_message, cur.blk);
      end
      chk_v("core_in", {256'd0, core_in}, {256'd0, tb_h});
      chk_b("start_in_ready", in_ready, 1'b0);
      $display("core_start #%0d at cycle %0d last=%0b", starts, cyc, cur.last);
      if (stub_on) begin
        pend      = 1'b1;
        pend_left = stub_lat;
        pend_res  = compress(core_in, core_message);
        pend_last = cur.last;
        stale     = 1'b0;
      end
    end else if (pend) begin
      if (!stale) chk_b("wait_in_ready", in_ready, 1'b0);
      pend_left--;
      if (pend_left == 0) begin
        core_done   = 1'b1;
        core_sha256 = pend_res;
        pend        = 1'b0;
        if (!stale) tb_h = pend_last ? IV : pend_res;
      end
    end
    if (digest_valid) begin
      digests_seen++;
      chk_i("digest_expected", int'(exp_dig_q.size() > 0), 1);
      if (exp_dig_q.size() > 0) chk_v("digest", {256'd0, digest}, {256'd0, exp_dig_q.pop_front()});
      $display("digest_valid at cycle %0d digest=%h", cyc, digest);
    end
    if (error) begin
      errors_seen++;
      err_cyc = cyc;
      tb_h = IV;
      chk_b("error_expected", 1'b1, expect_error);
      $display("error pulse at cycle %0d", cyc);
    end
  endtask

  // Pushes expected blocks/digest from the padding model, then streams msg_q.
  task automatic send_msg(input bit push_dig, input bit have_known,
                          input logic [7:0][31:0] known, input bit drop_valid);
    byte unsigned p[$];
    logic [63:0] blen;
    logic [7:0][31:0] h;
    logic [31:0] w;
    exp_blk_t e;
    int n, nw, nb, budget;
    bit rdy;
    n = msg_q.size();
    p = msg_q;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    blen = 64'(n) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(blen[8*k +: 8]);
    nb = p.size() / 64;
    h = IV;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 16; j++)
        e.blk[j] = {p[64*b+4*j], p[64*b+4*j+1], p[64*b+4*j+2], p[64*b+4*j+3]};
      e.last = (b == nb - 1);
      exp_blk_q.push_back(e);
      h = compress(h, e.blk);
    end
    if (push_dig) exp_dig_q.push_back(have_known ? known : h);
    $display("send message of %0d bytes, %0d blocks expected", n, nb);
    nw = (n + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      for (int j = 0; j < 4; j++)
        w[31-8*j -: 8] = (4*i + j < n) ? msg_q[4*i+j] : 8'hA5;
      in_valid = 1'b1;
      in_data  = w;
      in_last  = (i == nw - 1);
      in_bytes = (i == nw - 1) ? 2'(n % 4) : 2'($urandom_range(0, 3));
      budget = 0;
      do begin
        rdy = in_ready;
        tick();
        budget++;
      end while (!rdy && budget < 400);
      chk_b("word_accept", rdy, 1'b1);
    end
    if (drop_valid) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int budget;
    budget = 0;
    while ((exp_dig_q.size() != 0 || pend || busy !== 1'b0) && budget < 3000) begin
      tick();
      budget++;
    end
    chk_i(tag, int'(budget < 3000), 1);
  endtask

  initial begin
    int s0, d0, e0, budget;
    string s;
    tb_h = IV;

    reset = 1'b1;
    tick();
    tick();
    chk_b("rst_in_ready", in_ready, 1'b0);
    chk_b("rst_core_start", core_start, 1'b0);
    chk_b("rst_digest_valid", digest_valid, 1'b0);
    chk_b("rst_error", error, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_v("rst_digest", {256'd0, digest}, 512'd0);
    reset = 1'b0;
    tick();
    chk_b("idle_in_ready", in_ready, 1'b1);
    chk_b("idle_busy", busy, 1'b0);

    // "abc": one block
    msg_q = '{8'h61, 8'h62, 8'h63};
    s0 = starts;
    send_msg(1'b1, 1'b1, ABC_D, 1'b1);
    wait_idle("abc_done");
    chk_i("abc_starts", starts - s0, 1);
    chk_v("abc_digest_held", {256'd0, digest}, {256'd0, ABC_D});

    // 56-byte message: marker overruns into an extra length-only block
    s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    s0 = starts;
    send_msg(1'b1, 1'b1, LONG_D, 1'b1);
    wait_idle("long_done");
    chk_i("long_starts", starts - s0, 2);

    // Lengths 64, 55, 59, 61 hit the idx 15/13/14 boundaries
    foreach (msg_q[i]) msg_q[i] = 8'h00;
    for (int len_i = 0; len_i < 4; len_i++) begin
      int len;
      len = (len_i == 0) ? 64 : (len_i == 1) ? 55 : (len_i == 2) ? 59 : 61;
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back(8'(i * 7 + 3 + len));
      s0 = starts;
      send_msg(1'b1, 1'b0, IV, 1'b1);
      wait_idle("len_done");
      chk_i("len_starts", starts - s0, (len == 55) ? 1 : 2);
    end

    // Core never answers: timeout error
    stub_on = 1'b0;
    expect_error = 1'b1;
    e0 = errors_seen;
    d0 = digests_seen;
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b0, 1'b0, IV, 1'b1);
    budget = 0;
    while (errors_seen == e0 && budget < 200) begin
      tick();
      budget++;
    end
    chk_i("tmo_seen", errors_seen - e0, 1);
    chk_i("tmo_latency", err_cyc - start_cyc, int'(TMO));
    tick();
    chk_b("tmo_error_pulse", error, 1'b0);
    chk_b("tmo_in_ready", in_ready, 1'b1);
    chk_b("tmo_busy", busy, 1'b0);
    chk_i("tmo_no_digest", digests_seen - d0, 0);
    stub_on = 1'b1;
    expect_error = 1'b0;

    // Reset while waiting on the core; its late done must be ignored
    stub_lat = 30;
    s0 = starts;
    d0 = digests_seen;
    send_msg(1'b0, 1'b0, IV, 1'b1);
    budget = 0;
    while (starts == s0 && budget < 100) begin
      tick();
      budget++;
    end
    chk_i("rw_started", starts - s0, 1);
    tick();
    tick();
    reset = 1'b1;
    stale = 1'b1;
    tb_h = IV;
    tick();
    chk_b("rw_rst_busy", busy, 1'b0);
    chk_b("rw_rst_in_ready", in_ready, 1'b0);
    tick();
    reset = 1'b0;
    repeat (40) tick();
    chk_b("rw_idle", busy, 1'b0);
    chk_i("rw_no_digest", digests_seen - d0, 0);
    stub_lat = 3;
    send_msg(1'b1, 1'b1, ABC_D, 1'b1);
    wait_idle("rw_abc_done");

    // Back-to-back with in_valid held high between messages
    d0 = digests_seen;
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b1, 1'b1, ABC_D, 1'b0);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    send_msg(1'b1, 1'b1, LONG_D, 1'b1);
    wait_idle("b2b_done");
    chk_i("b2b_digests", digests_seen - d0, 2);
    chk_i("blocks_consumed", exp_blk_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
